sdp_mem_ctrl: RTL and testbench

SDP_MEM_CTRL -- requirements
Module: sdp_mem_ctrl

---
 rtl/sdp_mem_ctrl.sv | 140 ++++++++++++++
 tb/tb_sdp_mem_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_mem_ctrl.sv
// Request/response front end for a simple dual-port RAM with 1-cycle read latency and a 2-entry response FIFO.
// Define SDP_MEM_CTRL_CLEAR_EN to zero the whole memory after reset before accepting traffic.
module sdp_mem_ctrl #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 10
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [AW-1:0]   req_addr_i,
  input  logic [DW-1:0]   req_wdata_i,
  input  logic [DW/8-1:0] req_wsel_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_rdata_o,
  output logic            mem_en_a_o,
  output logic [AW-1:0]   mem_addr_a_o,
  input  logic [DW-1:0]   mem_rdata_a_i,
  output logic            mem_en_b_o,
  output logic [AW-1:0]   mem_addr_b_o,
  output logic [DW-1:0]   mem_wdata_b_o,
  output logic [DW/8-1:0] mem_wsel_b_o,
  output logic            init_done_o
);

  logic          ready_st_c;
  logic          clr_act_c;
  logic [AW-1:0] clr_addr_c;

`ifdef SDP_MEM_CTRL_CLEAR_EN
  typedef enum logic {CLEAR, READY} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Sweep one address per cycle; leave CLEAR after the top address is written.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_act_c = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_act_c = !rst_i;
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == '1) state_d = READY;
      end
      READY: ;
    endcase
  end

  assign ready_st_c = (state_q == READY);
  assign clr_addr_c = clr_cnt_q;
`else
  assign ready_st_c = 1'b1;
  assign clr_act_c  = 1'b0;
  assign clr_addr_c = '0;
`endif

  logic          active_c;
  logic          rd_acc_c;
  logic          wr_acc_c;
  logic          push_c;
  logic          pop_c;
  logic [2:0]    occ_c;
  logic          credit_ok_c;

  logic          inflight_q, inflight_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] fifo_q [2];
  logic [DW-1:0] fifo_d [2];

  // Outputs are forced low while reset is asserted, even in the no-clear build.
  assign active_c    = ready_st_c && !rst_i;
  assign pop_c       = rsp_valid_o && rsp_ready_i;
  assign push_c      = inflight_q;
  assign occ_c       = 3'(cnt_q) + 3'(inflight_q) - 3'(pop_c);
  assign credit_ok_c = (occ_c < 3'd2);

  assign req_ready_o = active_c && (req_we_i || credit_ok_c);
  assign rd_acc_c    = req_valid_i && req_ready_o && !req_we_i;
  assign wr_acc_c    = req_valid_i && req_ready_o && req_we_i;

  assign mem_en_a_o    = rd_acc_c;
  assign mem_addr_a_o  = rd_acc_c ? req_addr_i : '0;
  assign mem_en_b_o    = wr_acc_c || clr_act_c;
  assign mem_addr_b_o  = clr_act_c ? clr_addr_c : (wr_acc_c ? req_addr_i : '0);
  assign mem_wdata_b_o = wr_acc_c ? req_wdata_i : '0;
  assign mem_wsel_b_o  = clr_act_c ? '1 : (wr_acc_c ? req_wsel_i : '0);

  assign rsp_valid_o = (cnt_q != 2'd0);
  assign rsp_rdata_o = fifo_q[rd_ptr_q];
  assign init_done_o = active_c;

  // Read data lands the cycle after the RAM enable and goes straight into the FIFO.
  always_comb begin
    inflight_d = rd_acc_c;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_d     = fifo_q;
    if (push_c) begin
      fifo_d[wr_ptr_q] = mem_rdata_a_i;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop_c) rd_ptr_d = ~rd_ptr_q;
    cnt_d = cnt_q + 2'(push_c) - 2'(pop_c);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight_q <= 1'b0;
      cnt_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
    end else begin
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_q[0]  <= fifo_d[0];
      fifo_q[1]  <= fifo_d[1];
    end
  end

endmodule

// File: tb/tb_sdp_mem_ctrl.sv
// Scoreboard bench for sdp_mem_ctrl (DW=32, AW=4) with a behavioural 1-cycle-latency RAM.
module tb_sdp_mem_ctrl;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [3:0]    req_wsel = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          mem_en_a;
  logic [AW-1:0] mem_addr_a;
  logic [DW-1:0] mem_rdata_a;
  logic          mem_en_b;
  logic [AW-1:0] mem_addr_b;
  logic [DW-1:0] mem_wdata_b;
  logic [3:0]    mem_wsel_b;
  logic          init_done;

  int n_chk = 0;
  int n_pass = 0;
  logic [DW-1:0] exp_q [$];

  sdp_mem_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wsel_i(req_wsel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .mem_en_a_o(mem_en_a), .mem_addr_a_o(mem_addr_a), .mem_rdata_a_i(mem_rdata_a),
    .mem_en_b_o(mem_en_b), .mem_addr_b_o(mem_addr_b), .mem_wdata_b_o(mem_wdata_b),
    .mem_wsel_b_o(mem_wsel_b), .init_done_o(init_done)
  );

  always #5 clk = ~clk;

  // RAM model: byte-masked write port, registered read port that holds when not enabled.
  logic [DW-1:0] ram [16];
  bit            ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 16; i++) begin
`ifdef SDP_MEM_CTRL_CLEAR_EN
        ram[i] <= 32'hA5A5_0000 | 32'(i);
`else
        ram[i] <= 32'h0;
`endif
      end
      ram_init <= 1'b1;
    end else if (mem_en_b) begin
      for (int b = 0; b < 4; b++)
        if (mem_wsel_b[b]) ram[mem_addr_b][8*b +: 8] <= mem_wdata_b[8*b +: 8];
    end
    if (mem_en_a) mem_rdata_a <= ram[mem_addr_a];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Response monitor: every valid cycle must present the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst_i && rsp_valid) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      else begin
        chk("rsp_data", rsp_rdata, exp_q[0]);
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_wsel = s;
    @(negedge clk);
    chk("wr_ready", 32'(req_ready), 32'd1);
    chk("wr_en_b", 32'(mem_en_b), 32'd1);
    chk("wr_addr_b", 32'(mem_addr_b), 32'(a));
    chk("wr_wdata_b", mem_wdata_b, d);
    chk("wr_wsel_b", 32'(mem_wsel_b), 32'(s));
    nxt();
    req_valid = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, input logic [31:0] e);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    @(negedge clk);
    chk("rd_ready", 32'(req_ready), 32'd1);
    chk("rd_en_a", 32'(mem_en_a), 32'd1);
    chk("rd_addr_a", 32'(mem_addr_a), 32'(a));
    exp_q.push_back(e);
    nxt();
  endtask

  task automatic idle_chk(input int n, input logic v);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rsp_valid", 32'(rsp_valid), 32'(v));
      nxt();
    end
  endtask

  task automatic sweep(input int n);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd5; req_wdata = 32'hFFFF_FFFF; req_wsel = 4'hF;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("clr_en_b", 32'(mem_en_b), 32'd1);
      chk("clr_addr_b", 32'(mem_addr_b), 32'(i));
      chk("clr_wdata_b", mem_wdata_b, 32'd0);
      chk("clr_wsel_b", 32'(mem_wsel_b), 32'hF);
      chk("clr_ready", 32'(req_ready), 32'd0);
      chk("clr_init_done", 32'(init_done), 32'd0);
      nxt();
    end
    req_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_en_a", 32'(mem_en_a), 32'd0);
    chk("rst_en_b", 32'(mem_en_b), 32'd0);
    chk("rst_addr_b", 32'(mem_addr_b), 32'd0);
    chk("rst_wdata_b", mem_wdata_b, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
  endtask

  initial begin
    int accepted;
    logic [31:0] exp3;
    // Reset with a write request pending: nothing may leak out.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd5; req_wdata = 32'hFFFF_FFFF; req_wsel = 4'hF;
    nxt();
    @(negedge clk);
    chk_reset_outputs();
    nxt();
    rst_i = 1'b0;
    req_valid = 1'b0;
`ifdef SDP_MEM_CTRL_CLEAR_EN
    sweep(9);
    @(negedge clk);
    #2 rst_i = 1'b1;
    #1 chk_reset_outputs();
    nxt();
    rst_i = 1'b0;
    sweep(16);
`endif
    @(negedge clk);
    chk("init_done", 32'(init_done), 32'd1);
    nxt();

    // Cleared (or zero) location, with response latency checks.
    do_read(4'd7, 32'h0);
    req_valid = 1'b0;
    idle_chk(1, 1'b0);
    idle_chk(1, 1'b1);

    // Byte-masked write followed immediately by a read of the same word.
    do_write(4'd3, 32'hDEAD_BEEF, 4'b0101);
    do_read(4'd3, 32'h00AD_00EF);
    req_valid = 1'b0;
    idle_chk(1, 1'b0);
    idle_chk(1, 1'b1);

    for (int i = 0; i < 8; i++) do_write(4'(8 + i), 32'hC0DE_0000 + 32'(i), 4'hF);

    // Eight back-to-back reads at full rate.
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 4'(8 + i);
      @(negedge clk);
      chk("b2b_ready", 32'(req_ready), 32'd1);
      if (i >= 2) chk("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
      exp_q.push_back(32'hC0DE_0000 + 32'(i));
      nxt();
    end
    req_valid = 1'b0;
    idle_chk(2, 1'b1);
    idle_chk(1, 1'b0);

    // Back-pressure: only two reads fit, writes still go through.
    rsp_ready = 1'b0;
    accepted = 0;
    for (int k = 0; k < 6; k++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 4'(8 + k);
      @(negedge clk);
      if (req_ready) begin
        accepted++;
        exp_q.push_back(32'hC0DE_0000 + 32'(k));
      end
      nxt();
    end
    chk("stall_accepted", 32'(accepted), 32'd2);
    do_write(4'd2, 32'h1234_5678, 4'hF);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd2;
    @(negedge clk);
    chk("stall_rd_ready", 32'(req_ready), 32'd0);
    chk("stall_en_a", 32'(mem_en_a), 32'd0);
    nxt();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    idle_chk(2, 1'b1);
    idle_chk(1, 1'b0);

    // Reset with a read in flight: its response must never appear.
    do_read(4'd8, 32'hC0DE_0000);
    req_we = 1'b1; req_addr = 4'd1;
    @(negedge clk);
    #2 rst_i = 1'b1;
    #1 chk_reset_outputs();
    exp_q.delete();
    nxt();
    nxt();
    rst_i = 1'b0;
    req_valid = 1'b0;
`ifdef SDP_MEM_CTRL_CLEAR_EN
    sweep(16);
    exp3 = 32'h0;
`else
    exp3 = 32'h00AD_00EF;
`endif
    idle_chk(3, 1'b0);
    do_read(4'd3, exp3);
    req_valid = 1'b0;
    idle_chk(1, 1'b0);
    idle_chk(1, 1'b1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) nxt();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
